// File: rtl/mult_div_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult_div_unit : iterative HI/LO multiply/divide unit, one radix-2 step per cycle.
// Macro MDU_DIV_EN adds DIV/DIVU; without it those op codes are no-ops.  Rev 1.0
// ---------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int         CW       = $clog2(WIDTH);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_DIV_EN
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   work_hi, work_lo, opnd;
    logic               neg_lo;
    logic               accept, arith_op, signed_op, last_step;
    logic [WIDTH-1:0]   step_hi, step_lo, res_hi, res_lo;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod;
`ifdef MDU_DIV_EN
    logic               is_div, neg_hi, div_ge;
    logic [WIDTH:0]     div_shift;
`endif

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    assign accept    = start && (state != RUN);
    assign last_step = (state == RUN) && (count == CW'(WIDTH - 1));

    always_comb begin
        arith_op  = (op == OP_MULT) || (op == OP_MULTU);
        signed_op = (op == OP_MULT);
`ifdef MDU_DIV_EN
        arith_op  = arith_op || (op == OP_DIV) || (op == OP_DIVU);
        signed_op = signed_op || (op == OP_DIV);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (accept && arith_op) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = (accept && arith_op) ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Work registers hold magnitudes; signs are applied only on the final write.
    always_comb begin
        mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
        prod    = {step_hi, step_lo};
        if (neg_lo) prod = -prod;
        res_hi  = prod[2*WIDTH-1:WIDTH];
        res_lo  = prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
        div_shift = {work_hi, work_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        if (is_div) begin
            step_hi = div_ge ? (div_shift[WIDTH-1:0] - opnd) : div_shift[WIDTH-1:0];
            step_lo = {work_lo[WIDTH-2:0], div_ge};
            res_hi  = neg_hi ? -step_hi : step_hi;
            res_lo  = neg_lo ? -step_lo : step_lo;
            // Zero divisor: remainder already equals the dividend; quotient is forced.
            if (opnd == '0) res_lo = '1;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            work_hi <= '0;
            work_lo <= '0;
            opnd    <= '0;
            neg_lo  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
`ifdef MDU_DIV_EN
            is_div  <= 1'b0;
            neg_hi  <= 1'b0;
`endif
        end else if (accept) begin
            if (op == OP_MTHI) hi <= a;
            if (op == OP_MTLO) lo <= a;
            if (arith_op) begin
                count   <= '0;
                work_hi <= '0;
                work_lo <= mag(a, signed_op);
                opnd    <= mag(b, signed_op);
                neg_lo  <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MDU_DIV_EN
                is_div  <= op[1];
                neg_hi  <= signed_op && a[WIDTH-1];
`endif
            end
        end else if (state == RUN) begin
            work_hi <= step_hi;
            work_lo <= step_lo;
            if (last_step) begin
                count <= '0;
                hi    <= res_hi;
                lo    <= res_lo;
            end else begin
                count <= count + 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// tb_mult_div_unit : directed and random checks of mult_div_unit (WIDTH=32)
// against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;
    localparam int WIDTH = 32;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy;
        logic [63:0] ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            3'd0: return sx * sy;
            3'd1: return ux * uy;
            3'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(sx % sy), 32'(sx / sy)};
            end
            3'd3: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {32'(ux % uy), 32'(ux / uy)};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic pulse_start(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the falling edge of the done cycle.
    task automatic await_done(input string tag, input int already, input logic [63:0] exp);
        int busy_n = already;
        int guard  = 0;
        while (!done && guard < 100) begin
            if (busy) busy_n++;
            @(negedge clk);
            guard++;
        end
        check({tag, " busy cycles"}, 64'(busy_n), 64'(WIDTH));
        check({tag, " done"}, {63'd0, done}, 64'd1);
        check({tag, " busy with done"}, {63'd0, busy}, 64'd0);
        check({tag, " hi:lo"}, {hi, lo}, exp);
        {model_hi, model_lo} = exp;
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        check({tag, " idle busy/done"}, {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        logic [63:0] exp;
        int          kind, dones;

        reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
        #12;
        check("reset busy/done", {62'd0, busy, done}, 64'd0);
        check("reset hi:lo", {hi, lo}, 64'd0);

        // First edge after release accepts the op; MULT 3 * -5
        @(negedge clk);
        reset = 1'b0;
        pulse_start(3'd0, 32'd3, 32'hFFFF_FFFB);
        await_done("MULT 3*-5", 0, 64'hFFFF_FFFF_FFFF_FFF1);
        expect_idle("MULT 3*-5");

        // MULTU with an ignored start during RUN
        pulse_start(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        await_done("MULTU max", 5, 64'hFFFF_FFFE_0000_0001);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("MULTU no extra done", 64'(dones), 64'd0);

`ifdef MDU_DIV_EN
        pulse_start(3'd2, 32'hFFFF_FFF9, 32'd2);
        await_done("DIV -7/2", 0, 64'hFFFF_FFFF_FFFF_FFFD);
        expect_idle("DIV -7/2");
        pulse_start(3'd3, 32'd100, 32'd0);
        await_done("DIVU 100/0", 0, 64'h0000_0064_FFFF_FFFF);
        expect_idle("DIVU 100/0");
        pulse_start(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        await_done("DIV min/-1", 0, 64'h0000_0000_8000_0000);
        expect_idle("DIV min/-1");
`else
        pulse_start(3'd2, 32'd10, 32'd2);
        repeat (3) begin
            check("DIV disabled busy/done", {62'd0, busy, done}, 64'd0);
            @(negedge clk);
        end
        check("DIV disabled hi:lo", {hi, lo}, {model_hi, model_lo});
`endif

        // MTHI then MTLO on consecutive edges
        start = 1'b1; op = 3'd4; a = 32'h1234_5678; b = '0;
        @(posedge clk);
        @(negedge clk);
        check("MTHI done", {63'd0, done}, 64'd0);
        op = 3'd5; a = 32'h9ABC_DEF0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("MTLO busy/done", {62'd0, busy, done}, 64'd0);
        check("MTHI/MTLO hi:lo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
        {model_hi, model_lo} = 64'h1234_5678_9ABC_DEF0;

        // Back-to-back: second start accepted during the DONE cycle
        pulse_start(3'd0, 32'd7, 32'd9);
        await_done("b2b first", 0, 64'd63);
        pulse_start(3'd1, 32'h0001_0000, 32'h0001_0000);
        await_done("b2b second", 0, 64'h0000_0001_0000_0000);
        expect_idle("b2b second");

        // Reset in RUN cycle 10 aborts the op
        pulse_start(3'd0, 32'h0000_1234, 32'h0000_5678);
        repeat (9) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort busy/done", {62'd0, busy, done}, 64'd0);
        check("abort hi:lo", {hi, lo}, 64'd0);
        model_hi = '0; model_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort no done", 64'(dones), 64'd0);
        check("abort hi:lo held", {hi, lo}, 64'd0);

        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 5);
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 5) == 0) rb = 32'd0;
            if ($urandom_range(0, 9) == 0) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            if (kind == 4) ro = 3'd4 + 3'($urandom_range(0, 1));
            else if (kind == 5) ro = 3'd6 + 3'($urandom_range(0, 1));
            else ro = 3'(kind);
`ifdef MDU_DIV_EN
            if (kind < 4) begin
`else
            if (kind < 2) begin
`endif
                exp = ref_result(ro, ra, rb);
                pulse_start(ro, ra, rb);
                await_done($sformatf("rand%0d op%0d", i, ro), 0, exp);
            end else begin
                if (ro == 3'd4) model_hi = ra;
                if (ro == 3'd5) model_lo = ra;
                pulse_start(ro, ra, rb);
                check($sformatf("rand%0d op%0d busy/done", i, ro), {62'd0, busy, done}, 64'd0);
                check($sformatf("rand%0d op%0d hi:lo", i, ro), {hi, lo}, {model_hi, model_lo});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
